// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the adder/subtractor BCD display path.
//   DIG_MINUS / DIG_BLANK : non-numeric digit codes fed to the segment decoder
//   state_t               : conversion sequencer states (IDLE, SHIFT, DONE)
//   seg_decode()          : 4-bit digit code -> active-low segments {g..a}
//   dec_digits()          : decimal digit count of the largest value held in
//                           a given number of bits (used for sizing checks)
// ---------------------------------------------------------------------------
package disp_pkg;

    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hB;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Segment order is bit0 = a ... bit6 = g, and a 0 lights the segment.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:      seg = 7'h40;
            4'd1:      seg = 7'h79;
            4'd2:      seg = 7'h24;
            4'd3:      seg = 7'h30;
            4'd4:      seg = 7'h19;
            4'd5:      seg = 7'h12;
            4'd6:      seg = 7'h02;
            4'd7:      seg = 7'h78;
            4'd8:      seg = 7'h00;
            4'd9:      seg = 7'h10;
            DIG_MINUS: seg = 7'h3F;
            default:   seg = 7'h7F;
        endcase
        return seg;
    endfunction

    function automatic int dec_digits(input int bits);
        longint unsigned v;
        int n;
        v = (64'd1 << bits) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-add-3 (double-dabble) binary to BCD converter.
// One bit is consumed per clock, so a conversion takes BIN_W cycles after
// the load cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture bin and start a conversion (ignored bits of state
//                from any previous conversion are discarded)
//   bin        : binary value to convert
//   busy       : high while shifts remain
//   done       : high during the final shift cycle; bcd is valid after it
//   bcd        : BCD_D packed nibbles, digit 0 in the low nibble
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int BIN_W = 9,
    parameter int BCD_D = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [BIN_W-1:0]   bin,
    output logic               busy,
    output logic               done,
    output logic [4*BCD_D-1:0] bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]   bin_q;
    logic [4*BCD_D-1:0] bcd_q;
    logic [4*BCD_D-1:0] adj;
    logic [CNT_W-1:0]   cnt_q;

    // Pre-shift correction: any nibble of 5 or more would become 10+ after
    // doubling, so bias it by 3 to make the carry land in the next nibble.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_D; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign done = busy && (cnt_q == CNT_W'(1));
    assign bcd  = bcd_q;

    // Shift the corrected BCD register and the binary register as one long
    // word, MSB of the binary side feeding the BCD LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
        end else if (load) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt_q <= CNT_W'(BIN_W);
            busy  <= 1'b1;
        end else if (busy) begin
            bcd_q <= {adj[4*BCD_D-2:0], bin_q[BIN_W-1]};
            bin_q <= bin_q << 1;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/addsub_bcd_disp.sv
// ---------------------------------------------------------------------------
// addsub_bcd_disp
// Adds or subtracts two unsigned operands, converts the WIDTH+1-bit result
// to BCD with a sequential converter, and scans it onto a multiplexed
// common-anode 7-segment display with leading-zero blanking.
// The conversion loop free-runs: IDLE (sample) -> SHIFT x WIDTH+1 -> DONE.
//   clk, rst_n : clock, asynchronous active-low reset
//   a, b       : unsigned operands
//   sub        : 0 = a+b, 1 = a-b
//   sseg       : active-low segments, bit0 = a ... bit6 = g
//   an         : active-low one-cold anode enables, index 0 = units
//   busy       : conversion in progress
//   upd        : one-cycle pulse after the display register loads
// Build option: define SIGNED_RESULT_EN to show a negative difference as
// a magnitude with a minus sign in the top digit; otherwise the raw
// WIDTH+1-bit result is shown as an unsigned number.
// ---------------------------------------------------------------------------
module addsub_bcd_disp
    import disp_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              sub,
    output logic [6:0]        sseg,
    output logic [DIGITS-1:0] an,
    output logic              busy,
    output logic              upd
);

    localparam int RES_W = WIDTH + 1;
    localparam int BCD_D = DIGITS - 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    // The top digit is reserved for the sign, so the rest must hold the
    // largest possible result.
    if (BCD_D < dec_digits(RES_W)) begin : g_digit_check
        $error("addsub_bcd_disp: DIGITS too small for WIDTH");
    end

    state_t             state;
    logic [RES_W-1:0]   res_mag;
    logic               res_neg;
    logic               neg_pend;
    logic               conv_busy;
    logic               conv_done;
    logic [4*BCD_D-1:0] conv_bcd;
    logic [4*BCD_D-1:0] disp_bcd;
    logic               disp_neg;
    logic [REF_W-1:0]   ref_cnt;
    logic [IDX_W-1:0]   scan_idx;
    logic [DIGITS-1:0]  lead_zero;
    logic [3:0]         cur_code;

    // Result magnitude and sign from the live operands; only consumed in
    // IDLE, so changes during a conversion have no effect.
    always_comb begin
`ifdef SIGNED_RESULT_EN
        res_neg = sub && (a < b);
        if (res_neg) begin
            res_mag = {1'b0, b} - {1'b0, a};
        end else if (sub) begin
            res_mag = {1'b0, a} - {1'b0, b};
        end else begin
            res_mag = {1'b0, a} + {1'b0, b};
        end
`else
        res_neg = 1'b0;
        if (sub) begin
            res_mag = {1'b0, a} - {1'b0, b};
        end else begin
            res_mag = {1'b0, a} + {1'b0, b};
        end
`endif
    end

    bin2bcd_seq #(
        .BIN_W (RES_W),
        .BCD_D (BCD_D)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == IDLE),
        .bin   (res_mag),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Conversion sequencer. The display register is written only in DONE
    // so a partially shifted value is never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            upd      <= 1'b0;
            neg_pend <= 1'b0;
            disp_bcd <= '0;
            disp_neg <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                IDLE: begin
                    neg_pend <= res_neg;
                    busy     <= 1'b1;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (conv_done || !conv_busy) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    disp_bcd <= conv_bcd;
                    disp_neg <= neg_pend;
                    upd      <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // lead_zero[i] is set when digit i and every digit above it are zero;
    // the sign position has no BCD digit of its own.
    always_comb begin
        lead_zero = '0;
        lead_zero[DIGITS-1] = 1'b1;
        for (int i = BCD_D - 1; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (disp_bcd[4*i +: 4] == 4'd0);
        end
    end

    // Digit code for the slot about to be driven; units is never blanked.
    always_comb begin
        cur_code = DIG_BLANK;
        for (int i = 0; i < BCD_D; i++) begin
            if (int'(scan_idx) == i) begin
                cur_code = (i != 0 && lead_zero[i]) ? DIG_BLANK : disp_bcd[4*i +: 4];
            end
        end
        if (int'(scan_idx) == DIGITS - 1 && disp_neg) begin
            cur_code = DIG_MINUS;
        end
    end

    // Refresh scan: anode and segment registers load together on each
    // slot boundary so the new digit never appears on the old anode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            scan_idx <= '0;
            an       <= '1;
            sseg     <= 7'h7F;
        end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt  <= '0;
            an       <= ~(DIGITS'(1) << scan_idx);
            sseg     <= seg_decode(cur_code);
            scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_addsub_bcd_disp.sv
// ---------------------------------------------------------------------------
// tb_addsub_bcd_disp
// Self-checking bench for addsub_bcd_disp (WIDTH=8, DIGITS=4, REFRESH_DIV=4).
// A decimal model predicts upd/busy/an/sseg every cycle from the operand
// values present at each sample edge; directed vectors add literal checks
// of the scanned digits. Honours SIGNED_RESULT_EN like the design.
// ---------------------------------------------------------------------------
module tb_addsub_bcd_disp;

    localparam int WIDTH       = 8;
    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;
    localparam int PER         = WIDTH + 3;
    localparam int MOD         = 1 << (WIDTH + 1);

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             sub   = 1'b0;
    logic [6:0]       sseg;
    logic [3:0]       an;
    logic             busy;
    logic             upd;

    int vectors     = 0;
    int miscompares = 0;

    addsub_bcd_disp #(
        .WIDTH       (WIDTH),
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .sseg  (sseg),
        .an    (an),
        .busy  (busy),
        .upd   (upd)
    );

    always #5 clk = ~clk;

    // Model state: edge_n counts rising edges since reset release.
    int         edge_n   = 0;
    int         m_slot   = 0;
    int         m_mag    = 0;
    bit         m_neg    = 1'b0;
    int         p_mag    = 0;
    bit         p_neg    = 1'b0;
    logic [3:0] exp_an   = 4'hF;
    logic [6:0] exp_sseg = 7'h7F;
    logic       exp_upd  = 1'b0;
    logic       exp_busy = 1'b0;
    logic [6:0] obs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // 10 = minus, 11 = blank, else a decimal digit.
    function automatic int code_of(input int mag, input bit neg, input int idx);
        int p;
        p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
        if (idx == DIGITS - 1 && neg) return 10;
        if (idx > 0 && mag < p) return 11;
        return (mag / p) % 10;
    endfunction

    function automatic logic [6:0] seg_of(input int code);
        case (code)
            0:  return 7'h40;
            1:  return 7'h79;
            2:  return 7'h24;
            3:  return 7'h30;
            4:  return 7'h19;
            5:  return 7'h12;
            6:  return 7'h02;
            7:  return 7'h78;
            8:  return 7'h00;
            9:  return 7'h10;
            10: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    // Behavioural model advanced on every rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            edge_n   = 0;
            m_slot   = 0;
            m_mag    = 0;
            m_neg    = 1'b0;
            exp_an   = 4'hF;
            exp_sseg = 7'h7F;
            exp_upd  = 1'b0;
            exp_busy = 1'b0;
        end else begin
            int ai, bi, raw;
            edge_n++;
            if (edge_n % REFRESH_DIV == 0) begin
                exp_an   = ~(4'b0001 << m_slot);
                exp_sseg = seg_of(code_of(m_mag, m_neg, m_slot));
                m_slot   = (m_slot + 1) % DIGITS;
            end
            if (edge_n % PER == 1) begin
                ai  = int'(a);
                bi  = int'(b);
                raw = sub ? (ai - bi) : (ai + bi);
                raw = (raw + MOD) % MOD;
`ifdef SIGNED_RESULT_EN
                p_neg = sub && (ai < bi);
                p_mag = p_neg ? (bi - ai) : raw;
`else
                p_neg = 1'b0;
                p_mag = raw;
`endif
            end
            exp_upd = (edge_n % PER == 0);
            if (exp_upd) begin
                m_mag = p_mag;
                m_neg = p_neg;
            end
            exp_busy = (edge_n % PER != 0);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_an",   an,   4'hF);
            check("rst_sseg", sseg, 7'h7F);
            check("rst_busy", busy, 1'b0);
            check("rst_upd",  upd,  1'b0);
        end else begin
            check("upd",  upd,  exp_upd);
            check("busy", busy, exp_busy);
            check("an",   an,   exp_an);
            check("sseg", sseg, exp_sseg);
        end
    end

    task automatic applyStimulus(input int av, input int bv, input bit sv);
        @(posedge clk);
        #2;
        a   = WIDTH'(av);
        b   = WIDTH'(bv);
        sub = sv;
    endtask

    task automatic wait_upd(input string name, input int want_edge);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (upd !== 1'b1 && n < 4 * PER);
        if (want_edge >= 0) check(name, edge_n, want_edge);
        else                check(name, upd, 1'b1);
    endtask

    task automatic wait_edge(input string name, input int n);
        int g;
        g = 0;
        while (edge_n < n && g < 100) begin
            @(negedge clk);
            g++;
        end
        check(name, edge_n, n);
    endtask

    task automatic capture();
        logic [3:0] pat;
        for (int k = 0; k < 4; k++) obs[k] = 7'h7E;
        repeat (4 * REFRESH_DIV + 1) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                pat = ~(4'b0001 << k);
                if (an == pat) obs[k] = sseg;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0);
        capture();
        check({name, "_d3"}, obs[3], e3);
        check({name, "_d2"}, obs[2], e2);
        check({name, "_d1"}, obs[1], e1);
        check({name, "_d0"}, obs[0], e0);
    endtask

    task automatic settle();
        wait_upd("settle_upd_a", -1);
        wait_upd("settle_upd_b", -1);
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Scan order and "0" after reset, first upd latency and width.
        wait_edge("edge4", 4);
        check("scan1_an", an, 4'b1110);
        check("scan1_seg", sseg, 7'h40);
        wait_edge("edge8", 8);
        check("scan2_an", an, 4'b1101);
        check("scan2_seg", sseg, 7'h7F);
        wait_upd("first_upd_edge", 11);
        @(negedge clk);
        check("upd_width", upd, 1'b0);
        wait_edge("edge12", 12);
        check("scan3_an", an, 4'b1011);
        wait_edge("edge16", 16);
        check("scan4_an", an, 4'b0111);
        wait_upd("second_upd_edge", 22);

        applyStimulus(200, 55, 1'b0);
        settle();
        checkOutput("sum255", 7'h7F, 7'h24, 7'h12, 7'h12);

        applyStimulus(255, 255, 1'b0);
        settle();
        checkOutput("sum510", 7'h7F, 7'h12, 7'h79, 7'h40);

        applyStimulus(5, 10, 1'b1);
        settle();
`ifdef SIGNED_RESULT_EN
        checkOutput("diff_neg", 7'h3F, 7'h7F, 7'h7F, 7'h12);
`else
        checkOutput("diff_raw", 7'h7F, 7'h12, 7'h40, 7'h78);
`endif

        // Operand change in the middle of SHIFT must not disturb the
        // conversion already running.
        applyStimulus(10, 1, 1'b0);
        settle();
        repeat (4) @(posedge clk);
        #2 a = WIDTH'(99);
        wait_upd("mid_upd1", -1);
        check("mid_model1", m_mag, 11);
        wait_upd("mid_upd2", -1);
        check("mid_model2", m_mag, 100);
        checkOutput("mid_dut", 7'h7F, 7'h79, 7'h40, 7'h40);

        // Reset during SHIFT cycle 5.
        wait_upd("pre_rst_upd", -1);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_an",   an,   4'hF);
        check("arst_sseg", sseg, 7'h7F);
        check("arst_upd",  upd,  1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_edge("post_rst_edge4", 4);
        check("post_rst_an",  an,   4'b1110);
        check("post_rst_seg", sseg, 7'h40);
        wait_upd("post_rst_upd", 11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
